// File: rtl/ps2_scancode_decoder_if.sv
// Byte stream into the scan-code decoder and the key-event bus it produces.
// master = byte source / event consumer, slave = decoder.
interface ps2_scancode_decoder_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic [7:0]       in_data;
  logic             evt_valid;
  logic             evt_make;
  logic             evt_ext;
  logic [7:0]       evt_code;
  logic [7:0]       evt_ascii;
  logic             key_down;
  logic [7:0]       held_code;
  logic [CNT_W-1:0] key_count;
  logic             caps_lock;

  modport master (
    output in_valid, in_data,
    input  evt_valid, evt_make, evt_ext, evt_code, evt_ascii,
    input  key_down, held_code, key_count, caps_lock
  );

  modport slave (
    input  in_valid, in_data,
    output evt_valid, evt_make, evt_ext, evt_code, evt_ascii,
    output key_down, held_code, key_count, caps_lock
  );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scan-code decoder: strips E0/F0 prefixes, swallows Pause, drops typematic repeats.
// Define KBD_SHIFT_EN to add shift/caps-lock tracking and upper-case/shifted-digit ASCII.
module ps2_scancode_decoder #(
  parameter int CNT_W     = 8,
  parameter int PAUSE_LEN = 7
) (
  input  logic                  clk,
  input  logic                  resetn,
  ps2_scancode_decoder_if.slave bus
);
  localparam int PW = $clog2(PAUSE_LEN + 1);

  typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_PAUSE} state_t;

  state_t           state_reg;
  logic [PW-1:0]    pause_cnt_reg;
  logic             evt_valid_reg, evt_make_reg, evt_ext_reg;
  logic [7:0]       evt_code_reg, evt_ascii_reg, held_code_reg;
  logic             key_down_reg, held_ext_reg;
  logic [CNT_W-1:0] key_count_reg;
  logic             shift_reg, caps_reg;

  function automatic logic [7:0] to_ascii(input logic [7:0] code, input logic shift,
                                          input logic caps);
    logic [7:0] ch;
    ch = 8'h00;
    case (code)
      8'h1C: ch = 8'h61; 8'h32: ch = 8'h62; 8'h21: ch = 8'h63; 8'h23: ch = 8'h64;
      8'h24: ch = 8'h65; 8'h2B: ch = 8'h66; 8'h34: ch = 8'h67; 8'h33: ch = 8'h68;
      8'h43: ch = 8'h69; 8'h3B: ch = 8'h6A; 8'h42: ch = 8'h6B; 8'h4B: ch = 8'h6C;
      8'h3A: ch = 8'h6D; 8'h31: ch = 8'h6E; 8'h44: ch = 8'h6F; 8'h4D: ch = 8'h70;
      8'h15: ch = 8'h71; 8'h2D: ch = 8'h72; 8'h1B: ch = 8'h73; 8'h2C: ch = 8'h74;
      8'h3C: ch = 8'h75; 8'h2A: ch = 8'h76; 8'h1D: ch = 8'h77; 8'h22: ch = 8'h78;
      8'h35: ch = 8'h79; 8'h1A: ch = 8'h7A;
      8'h45: ch = 8'h30; 8'h16: ch = 8'h31; 8'h1E: ch = 8'h32; 8'h26: ch = 8'h33;
      8'h25: ch = 8'h34; 8'h2E: ch = 8'h35; 8'h36: ch = 8'h36; 8'h3D: ch = 8'h37;
      8'h3E: ch = 8'h38; 8'h46: ch = 8'h39;
      8'h29: ch = 8'h20; 8'h5A: ch = 8'h0D; 8'h66: ch = 8'h08;
      default: ch = 8'h00;
    endcase
    if (ch >= 8'h61 && ch <= 8'h7A && (shift ^ caps))
      ch = ch - 8'h20;
    // US layout shifted digit row: ! @ # $ % ^ & * ( )
    if (shift) begin
      case (code)
        8'h16: ch = 8'h21; 8'h1E: ch = 8'h40; 8'h26: ch = 8'h23; 8'h25: ch = 8'h24;
        8'h2E: ch = 8'h25; 8'h36: ch = 8'h5E; 8'h3D: ch = 8'h26; 8'h3E: ch = 8'h2A;
        8'h46: ch = 8'h28; 8'h45: ch = 8'h29;
        default: ;
      endcase
    end
    return ch;
  endfunction

  logic       err_byte, code_byte, cur_ext, repeat_hit, fire_make, fire_break;
  logic [7:0] ascii_next;

  always_comb begin
    err_byte   = (bus.in_data == 8'h00) || (bus.in_data == 8'hFF);
    code_byte  = !err_byte && (bus.in_data != 8'hE0) && (bus.in_data != 8'hF0);
    cur_ext    = (state_reg == S_EXT) || (state_reg == S_EXT_BRK);
    repeat_hit = key_down_reg && (bus.in_data == held_code_reg) && (cur_ext == held_ext_reg);
    fire_make  = bus.in_valid && code_byte &&
                 ((state_reg == S_IDLE && bus.in_data != 8'hE1) || state_reg == S_EXT);
    fire_break = bus.in_valid && code_byte &&
                 (state_reg == S_BRK || state_reg == S_EXT_BRK);
    ascii_next = cur_ext ? 8'h00 : to_ascii(bus.in_data, shift_reg, caps_reg);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= S_IDLE;
      pause_cnt_reg <= '0;
      evt_valid_reg <= 1'b0;
      evt_make_reg  <= 1'b0;
      evt_ext_reg   <= 1'b0;
      evt_code_reg  <= 8'h00;
      evt_ascii_reg <= 8'h00;
      key_down_reg  <= 1'b0;
      held_code_reg <= 8'h00;
      held_ext_reg  <= 1'b0;
      key_count_reg <= '0;
      shift_reg     <= 1'b0;
      caps_reg      <= 1'b0;
    end else begin
      evt_valid_reg <= 1'b0;
      if (bus.in_valid) begin
        if (state_reg == S_PAUSE) begin
          if (pause_cnt_reg == PW'(PAUSE_LEN - 1)) begin
            pause_cnt_reg <= '0;
            state_reg     <= S_IDLE;
          end else begin
            pause_cnt_reg <= pause_cnt_reg + 1'b1;
          end
        end else if (err_byte) begin
          state_reg <= S_IDLE;
        end else if (fire_make || fire_break) begin
          state_reg <= S_IDLE;
        end else begin
          // Only prefix bytes reach here.
          case (state_reg)
            S_IDLE: begin
              if (bus.in_data == 8'hE0)      state_reg <= S_EXT;
              else if (bus.in_data == 8'hF0) state_reg <= S_BRK;
              else begin
                state_reg     <= S_PAUSE;
                pause_cnt_reg <= '0;
              end
            end
            S_EXT:   if (bus.in_data == 8'hF0) state_reg <= S_EXT_BRK;
            S_BRK:   if (bus.in_data == 8'hE0) state_reg <= S_EXT_BRK;
            default: ;
          endcase
        end
      end

      if (fire_make && !repeat_hit) begin
        evt_valid_reg <= 1'b1;
        evt_make_reg  <= 1'b1;
        evt_ext_reg   <= cur_ext;
        evt_code_reg  <= bus.in_data;
        evt_ascii_reg <= ascii_next;
        key_down_reg  <= 1'b1;
        held_code_reg <= bus.in_data;
        held_ext_reg  <= cur_ext;
        key_count_reg <= key_count_reg + 1'b1;
      end
      if (fire_break) begin
        evt_valid_reg <= 1'b1;
        evt_make_reg  <= 1'b0;
        evt_ext_reg   <= cur_ext;
        evt_code_reg  <= bus.in_data;
        evt_ascii_reg <= ascii_next;
        if (bus.in_data == held_code_reg) key_down_reg <= 1'b0;
      end

`ifdef KBD_SHIFT_EN
      if (!cur_ext && (bus.in_data == 8'h12 || bus.in_data == 8'h59)) begin
        if (fire_make)  shift_reg <= 1'b1;
        if (fire_break) shift_reg <= 1'b0;
      end
      if (fire_make && !repeat_hit && !cur_ext && bus.in_data == 8'h58)
        caps_reg <= ~caps_reg;
`endif
    end
  end

  assign bus.evt_valid = evt_valid_reg;
  assign bus.evt_make  = evt_make_reg;
  assign bus.evt_ext   = evt_ext_reg;
  assign bus.evt_code  = evt_code_reg;
  assign bus.evt_ascii = evt_ascii_reg;
  assign bus.key_down  = key_down_reg;
  assign bus.held_code = held_code_reg;
  assign bus.key_count = key_count_reg;
  assign bus.caps_lock = caps_reg;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench for ps2_scancode_decoder: expected events queued as bytes are driven.
module tb_ps2_scancode_decoder;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  ps2_scancode_decoder_if #(.CNT_W(8)) bus ();

  ps2_scancode_decoder #(.CNT_W(8), .PAUSE_LEN(7)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic       make;
    logic       ext;
    logic [7:0] code;
    logic [7:0] ascii;
  } evt_t;

  evt_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

`ifdef KBD_SHIFT_EN
  localparam logic [7:0] SHIFT_A  = 8'h41;
  localparam logic       CAPS_EXP = 1'b1;
`else
  localparam logic [7:0] SHIFT_A  = 8'h61;
  localparam logic       CAPS_EXP = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_evt(input logic make, input logic ext, input logic [7:0] code,
                            input logic [7:0] ascii);
    evt_t e;
    e.make = make; e.ext = ext; e.code = code; e.ascii = ascii;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  always @(negedge clk) begin
    if (resetn && bus.evt_valid) begin
      if (exp_q.size() == 0) begin
        check("evt_unexpected", {24'h0, bus.evt_code}, 32'hFFFF_FFFF);
      end else begin
        evt_t e;
        e = exp_q.pop_front();
        check("evt_make", 32'(bus.evt_make), 32'(e.make));
        check("evt_ext", 32'(bus.evt_ext), 32'(e.ext));
        check("evt_code", 32'(bus.evt_code), 32'(e.code));
        check("evt_ascii", 32'(bus.evt_ascii), 32'(e.ascii));
      end
      $display("evt make=%0d ext=%0d code=%h ascii=%h", bus.evt_make, bus.evt_ext,
               bus.evt_code, bus.evt_ascii);
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    // 1: reset in the middle of a break prefix
    send(8'hF0);
    resetn = 1'b0;
    #1;
    check("rst_evt_valid", 32'(bus.evt_valid), 0);
    check("rst_key_down", 32'(bus.key_down), 0);
    check("rst_held_code", 32'(bus.held_code), 0);
    check("rst_key_count", 32'(bus.key_count), 0);
    check("rst_caps_lock", 32'(bus.caps_lock), 0);
    check("rst_evt_code", 32'(bus.evt_code), 0);
    @(negedge clk);
    resetn = 1'b1;
    expect_evt(1, 0, 8'h1C, 8'h61);
    send(8'h1C);
    @(negedge clk);
    check("t1_key_count", 32'(bus.key_count), 1);

    // 2: typematic repeat suppression
    do_reset();
    expect_evt(1, 0, 8'h1C, 8'h61);
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0);
    expect_evt(0, 0, 8'h1C, 8'h61);
    send(8'h1C);
    @(negedge clk);
    check("t2_key_count", 32'(bus.key_count), 1);
    check("t2_key_down", 32'(bus.key_down), 0);

    // 3: extended make / break
    do_reset();
    send(8'hE0);
    expect_evt(1, 1, 8'h75, 8'h00);
    send(8'h75);
    send(8'hE0); send(8'hF0);
    expect_evt(0, 1, 8'h75, 8'h00);
    send(8'h75);

    // 4: Pause sequence swallowed, then space; error byte drops a break prefix
    do_reset();
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    expect_evt(1, 0, 8'h29, 8'h20);
    send(8'h29);
    send(8'hF0); send(8'h00);
    expect_evt(1, 0, 8'h1C, 8'h61);
    send(8'h1C);
    @(negedge clk);
    check("t4_key_count", 32'(bus.key_count), 2);

    // 5: press counter wrap
    do_reset();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] c;
      c = (i % 2 == 0) ? 8'h1C : 8'h32;
      expect_evt(1, 0, c, (i % 2 == 0) ? 8'h61 : 8'h62);
      send(c);
      if (i == 254) begin
        @(negedge clk);
        check("t5_count_255", 32'(bus.key_count), 255);
      end
    end
    @(negedge clk);
    check("t5_count_wrap", 32'(bus.key_count), 0);

    // 6: shift and caps lock
    do_reset();
    expect_evt(1, 0, 8'h12, 8'h00);
    send(8'h12);
    expect_evt(1, 0, 8'h1C, SHIFT_A);
    send(8'h1C);
    send(8'hF0);
    expect_evt(0, 0, 8'h12, 8'h00);
    send(8'h12);
    send(8'hF0);
    expect_evt(0, 0, 8'h1C, 8'h61);
    send(8'h1C);
    expect_evt(1, 0, 8'h58, 8'h00);
    send(8'h58);
    expect_evt(1, 0, 8'h1C, SHIFT_A);
    send(8'h1C);
    @(negedge clk);
    check("t6_caps_lock", 32'(bus.caps_lock), 32'(CAPS_EXP));

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
